mem_dump_tx: RTL and testbench



---
 rtl/mem_dump_tx.sv | 131 +++++++++++++
 tb/tb_mem_dump_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - reads a range of 64-bit words from memory port B and sends them MSB-first as bytes to SPART
module mem_dump_tx #(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   output logic              enb,
   output logic              web,
   output logic [ADDR_W-1:0] addrb,
   input  logic [63:0]       doutb,
   input  logic              tbr,
   output logic              tx_we,
   output logic [7:0]        tx_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
      S_GAP,
      S_FIN
   } state_t;

   localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 1);
   localparam logic [ADDR_W:0] ONE_WORD  = (ADDR_W+1)'(1);

   state_t            state;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   remaining;
   logic [63:0]       shift;
   logic [3:0]        byte_idx;
   logic [1:0]        wait_cnt;
   logic [ADDR_W-1:0] next_addr;

   // Natural ADDR_W-bit overflow gives the wrap from the top word back to 0.
   assign next_addr = addr_reg + 1'b1;
   assign web       = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         enb       <= 1'b0;
         addrb     <= '0;
         tx_we     <= 1'b0;
         tx_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         addr_reg  <= '0;
         remaining <= '0;
         shift     <= '0;
         byte_idx  <= '0;
         wait_cnt  <= '0;
      end else begin
         enb   <= 1'b0;
         tx_we <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (num_words != '0) begin
                     addr_reg  <= base_addr;
                     remaining <= num_words;
                     addrb     <= base_addr;
                     enb       <= 1'b1;
                     busy      <= 1'b1;
                     state     <= S_READ;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_READ: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            // The WAIT cycle where the counter hits RD_LAT-1 is exactly RD_LAT cycles after enb.
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  shift    <= doutb;
                  byte_idx <= '0;
                  state    <= S_SEND;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_SEND: begin
               if (tbr) begin
                  tx_we    <= 1'b1;
                  tx_data  <= shift[63:56];
                  shift    <= {shift[55:0], 8'h00};
                  byte_idx <= byte_idx + 1'b1;
                  state    <= S_GAP;
               end
            end
            // tbr from SPART is still stale here, so this cycle never looks at it.
            S_GAP: begin
               if (byte_idx == 4'd8) begin
                  remaining <= remaining - 1'b1;
                  addr_reg  <= next_addr;
                  if (remaining == ONE_WORD) begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     addrb <= next_addr;
                     enb   <= 1'b1;
                     state <= S_READ;
                  end
               end else begin
                  state <= S_SEND;
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb/tb_mem_dump_tx.sv - directed bench for mem_dump_tx at read latencies 1 and 3
module tb_mem_dump_tx;
   localparam int AW = 14;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, tbr;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_words;
   logic          tbr3 = 1'b1;

   logic          enb1, web1, tx_we1, busy1, done1;
   logic [AW-1:0] addrb1;
   logic [7:0]    tx_data1;
   logic [63:0]   doutb1;
   logic          enb3, web3, tx_we3, busy3, done3;
   logic [AW-1:0] addrb3;
   logic [7:0]    tx_data3;
   logic [63:0]   doutb3, p0, p1;

   logic [63:0] mem [0:(1<<AW)-1];

   mem_dump_tx #(.ADDR_W(AW), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .enb(enb1), .web(web1), .addrb(addrb1), .doutb(doutb1), .tbr(tbr),
      .tx_we(tx_we1), .tx_data(tx_data1), .busy(busy1), .done(done1));

   mem_dump_tx #(.ADDR_W(AW), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .enb(enb3), .web(web3), .addrb(addrb3), .doutb(doutb3), .tbr(tbr3),
      .tx_we(tx_we3), .tx_data(tx_data3), .busy(busy3), .done(done3));

   // Memory models return junk unless the read was actually strobed.
   always @(posedge clk) begin
      doutb1 <= enb1 ? mem[addrb1] : 64'hDEAD_BEEF_DEAD_BEEF;
      p0     <= enb3 ? mem[addrb3] : 64'hDEAD_BEEF_DEAD_BEEF;
      p1     <= p0;
      doutb3 <= p1;
   end

   int   cyc = 0;
   logic tbr_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      tbr_q <= tbr;
   end

   logic [7:0]    by1[$], by3[$];
   logic [AW-1:0] ad1[$], ad3[$];
   int en_c1, en_c3, first1, first3, last1, last3;
   int dn1, dn3, dn_c1, dn_c3, bsy1, viol;

   always @(negedge clk) begin
      if (enb1) begin
         if (ad1.size() == 0) en_c1 = cyc;
         ad1.push_back(addrb1);
      end
      if (enb3) begin
         if (ad3.size() == 0) en_c3 = cyc;
         ad3.push_back(addrb3);
      end
      if (tx_we1) begin
         if (by1.size() == 0) first1 = cyc;
         by1.push_back(tx_data1);
         last1 = cyc;
         if (!tbr_q) viol++;
      end
      if (tx_we3) begin
         if (by3.size() == 0) first3 = cyc;
         by3.push_back(tx_data3);
         last3 = cyc;
      end
      if (done1) begin dn1++; dn_c1 = cyc; end
      if (done3) begin dn3++; dn_c3 = cyc; end
      if (busy1) bsy1++;
      if (web1 || web3) viol++;
   end

   int n_cmp = 0, n_bad = 0;
   int start_cyc = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      by1.delete(); by3.delete(); ad1.delete(); ad3.delete();
      en_c1 = 0; en_c3 = 0; first1 = 0; first3 = 0; last1 = 0; last3 = 0;
      dn1 = 0; dn3 = 0; dn_c1 = 0; dn_c3 = 0; bsy1 = 0; viol = 0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n);
      base_addr = b;
      num_words = n;
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (dn1 == 0 && k < budget) begin tick(); k++; end
      check({tag, "_done_seen"}, 64'(dn1 != 0), 64'd1);
      repeat (30) tick();
   endtask

   function automatic logic [63:0] word(input bit sel, input int w);
      logic [63:0] r = '0;
      for (int k = 0; k < 8; k++) begin
         if (!sel && 8*w+k < by1.size()) r = {r[55:0], by1[8*w+k]};
         if (sel && 8*w+k < by3.size()) r = {r[55:0], by3[8*w+k]};
      end
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; tbr = 1'b1; base_addr = '0; num_words = '0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = {32'(i), ~32'(i)};
      clear_logs();
      repeat (3) tick();
      check("reset_outputs1", 64'({enb1, web1, addrb1, tx_we1, tx_data1, busy1, done1}), 64'd0);
      check("reset_outputs3", 64'({enb3, web3, addrb3, tx_we3, tx_data3, busy3, done3}), 64'd0);
      rst = 1'b0;
      tick();

      // single word, tbr held high
      mem[14'h0010] = 64'h0123_4567_89AB_CDEF;
      clear_logs();
      pulse_start(14'h0010, 15'd1);
      wait_done("t1", 100);
      check("t1_enb_cnt", 64'(ad1.size()), 64'd1);
      check("t1_addr", 64'(ad1[0]), 64'h0010);
      check("t1_nbytes", 64'(by1.size()), 64'd8);
      check("t1_word", word(0, 0), 64'h0123_4567_89AB_CDEF);
      check("t1_first_byte", 64'(by1[0]), 64'h01);
      check("t1_done_cnt", 64'(dn1), 64'd1);
      check("t1_done_after_last_we", 64'(dn_c1 - last1), 64'd1);
      check("t1_latency", 64'(dn_c1 - start_cyc), 64'd19);
      check("t1_enb_to_we", 64'(first1 - en_c1), 64'd3);
      check("t1_busy_after", 64'(busy1), 64'd0);
      check("t1_viol", 64'(viol), 64'd0);
      // same word through the RD_LAT=3 instance
      check("t6_nbytes", 64'(by3.size()), 64'd8);
      check("t6_word", word(1, 0), 64'h0123_4567_89AB_CDEF);
      check("t6_addr", 64'(ad3[0]), 64'h0010);
      check("t6_latency", 64'(dn_c3 - start_cyc), 64'd21);
      check("t6_enb_to_we", 64'(first3 - en_c3), 64'd5);
      check("t6_done_cnt", 64'(dn3), 64'd1);

      // backpressure: tbr low for 20 cycles before every byte
      clear_logs();
      tbr = 1'b0;
      pulse_start(14'h0010, 15'd1);
      for (int i = 0; i < 8; i++) begin
         tbr = 1'b0;
         repeat (20) tick();
         tbr = 1'b1;
         k = 0;
         while (by1.size() == i && k < 10) begin tick(); k++; end
         tbr = 1'b0;
      end
      tbr = 1'b1;
      wait_done("t2", 100);
      check("t2_nbytes", 64'(by1.size()), 64'd8);
      check("t2_word", word(0, 0), 64'h0123_4567_89AB_CDEF);
      check("t2_viol", 64'(viol), 64'd0);
      check("t2_done_cnt", 64'(dn1), 64'd1);
      check("t2_enb_cnt", 64'(ad1.size()), 64'd1);

      // address wrap at the top of memory
      mem[14'h3FFF] = 64'hAABB_CCDD_EEFF_0011;
      mem[14'h0000] = 64'h5566_7788_99AA_BBCC;
      clear_logs();
      pulse_start(14'h3FFF, 15'd2);
      wait_done("t3", 200);
      check("t3_enb_cnt", 64'(ad1.size()), 64'd2);
      check("t3_addr0", 64'(ad1[0]), 64'h3FFF);
      check("t3_addr1", 64'(ad1[1]), 64'h0000);
      check("t3_nbytes", 64'(by1.size()), 64'd16);
      check("t3_word0", word(0, 0), 64'hAABB_CCDD_EEFF_0011);
      check("t3_word1", word(0, 1), 64'h5566_7788_99AA_BBCC);
      check("t3_ninth_byte", 64'(by1[8]), 64'h55);
      check("t3_word1_lat3", word(1, 1), 64'h5566_7788_99AA_BBCC);
      check("t3_addr1_lat3", 64'(ad3[1]), 64'h0000);

      // zero-length dump
      clear_logs();
      pulse_start(14'h0055, 15'd0);
      repeat (5) tick();
      check("t4_done_cnt", 64'(dn1), 64'd1);
      check("t4_done_lat", 64'(dn_c1 - start_cyc), 64'd1);
      check("t4_enb_cnt", 64'(ad1.size()), 64'd0);
      check("t4_nbytes", 64'(by1.size()), 64'd0);
      check("t4_busy_cnt", 64'(bsy1), 64'd0);

      // start while busy is ignored
      mem[14'h0020] = 64'h1111_2222_3333_4444;
      mem[14'h0021] = 64'h5555_6666_7777_8888;
      mem[14'h0022] = 64'h9999_AAAA_BBBB_CCCC;
      clear_logs();
      pulse_start(14'h0020, 15'd3);
      repeat (10) tick();
      pulse_start(14'h0100, 15'd5);
      wait_done("t4b", 300);
      check("t4b_nbytes", 64'(by1.size()), 64'd24);
      check("t4b_enb_cnt", 64'(ad1.size()), 64'd3);
      check("t4b_addr2", 64'(ad1[2]), 64'h0022);
      check("t4b_word2", word(0, 2), 64'h9999_AAAA_BBBB_CCCC);
      check("t4b_done_cnt", 64'(dn1), 64'd1);
      check("t4b_nbytes_lat3", 64'(by3.size()), 64'd24);

      // reset after the third byte of a two-word dump
      mem[14'h0030] = 64'hF0E1_D2C3_B4A5_9687;
      mem[14'h0031] = 64'h7869_5A4B_3C2D_1E0F;
      mem[14'h0040] = 64'hCAFE_F00D_1234_5678;
      clear_logs();
      pulse_start(14'h0030, 15'd2);
      k = 0;
      while (by1.size() < 3 && k < 100) begin tick(); k++; end
      check("t5_third_byte_seen", 64'(by1.size()), 64'd3);
      rst = 1'b1;
      tick();
      check("t5_outputs1", 64'({enb1, web1, addrb1, tx_we1, tx_data1, busy1, done1}), 64'd0);
      check("t5_outputs3", 64'({enb3, web3, addrb3, tx_we3, tx_data3, busy3, done3}), 64'd0);
      rst = 1'b0;
      clear_logs();
      repeat (40) tick();
      check("t5_no_tx_after_rst", 64'(by1.size()), 64'd0);
      check("t5_no_enb_after_rst", 64'(ad1.size()), 64'd0);
      pulse_start(14'h0040, 15'd1);
      wait_done("t5", 100);
      check("t5_addr", 64'(ad1[0]), 64'h0040);
      check("t5_nbytes", 64'(by1.size()), 64'd8);
      check("t5_word", word(0, 0), 64'hCAFE_F00D_1234_5678);
      check("t5_word_lat3", word(1, 0), 64'hCAFE_F00D_1234_5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
